// File: rtl/pm_lfsr_domain.sv
// Power-managed Fibonacci LFSR: sequencer isolates, saves, switches off, and restores on wake.
// Latency: pd_req -> OFF in SW_DLY+3 cycles; pu_req -> ON in SW_DLY+4 cycles. Requests are not queued.
module pm_lfsr_domain #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] TAPS    = 5'b10100,
  parameter logic [WIDTH-1:0] SEED    = 5'b00001,
  parameter int               SW_DLY  = 4,
  parameter logic [WIDTH-1:0] ISO_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed,
  input  logic             pd_req,
  input  logic             pu_req,
  output logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_bit,
  output logic [2:0]       pwr_state,
  output logic             busy,
  output logic             done,
  output logic             iso_en,
  output logic             save_en,
  output logic             restore_en,
  output logic             sw_en
);

  typedef enum logic [2:0] {
    S_ON      = 3'd0,
    S_ISO     = 3'd1,
    S_SAVE    = 3'd2,
    S_SWOFF   = 3'd3,
    S_OFF     = 3'd4,
    S_SWON    = 3'd5,
    S_RESTORE = 3'd6,
    S_DEISO   = 3'd7
  } state_e;

  localparam int CW = $clog2(SW_DLY + 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_st_q, lfsr_st_d;
  logic [WIDTH-1:0] ret_q, ret_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_ON;
      lfsr_st_q <= SEED;
      ret_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_st_q <= lfsr_st_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_st_d = lfsr_st_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_ON: begin
        if (pd_req)       state_d = S_ISO;
        else if (seed_ld) lfsr_st_d = seed;
        else if (en)      lfsr_st_d = {lfsr_st_q[WIDTH-2:0], ^(lfsr_st_q & TAPS)};
      end
      S_ISO: state_d = S_SAVE;
      S_SAVE: begin
        // Domain contents are lost as soon as the switch opens.
        ret_d     = lfsr_st_q;
        lfsr_st_d = '0;
        cnt_d     = '0;
        state_d   = S_SWOFF;
      end
      S_SWOFF: begin
        if (cnt_q == CW'(SW_DLY - 1)) begin
          cnt_d   = '0;
          state_d = S_OFF;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OFF: begin
        lfsr_st_d = '0;
        cnt_d     = '0;
        if (pu_req) state_d = S_SWON;
      end
      S_SWON: begin
        // Ramp-up holds one extra cycle for supply settle before restore.
        if (cnt_q == CW'(SW_DLY)) begin
          cnt_d     = '0;
          lfsr_st_d = ret_q;
          state_d   = S_RESTORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESTORE: state_d = S_DEISO;
      S_DEISO: begin
        state_d = S_ON;
        done_d  = 1'b1;
      end
      default: state_d = S_ON;
    endcase
  end

  assign iso_en     = (state_q != S_ON) && (state_q != S_DEISO);
  assign save_en    = (state_q == S_SAVE);
  assign restore_en = (state_q == S_RESTORE);
  assign sw_en      = (state_q != S_SWOFF) && (state_q != S_OFF);
  assign busy       = (state_q != S_ON) && (state_q != S_OFF);
  assign done       = done_q;
  assign pwr_state  = state_q;
  assign lfsr_q     = iso_en ? ISO_VAL : lfsr_st_q;
  assign lfsr_bit   = lfsr_q[WIDTH-1];

endmodule

// File: tb/tb_pm_lfsr_domain.sv
// Directed bench for pm_lfsr_domain: default 5-bit instance plus an 8-bit SW_DLY=1 instance.
module tb_pm_lfsr_domain;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 5-bit default instance
  logic       rst = 1'b0, en = 1'b0, seed_ld = 1'b0, pd_req = 1'b0, pu_req = 1'b0;
  logic [4:0] seed = 5'd0;
  logic [4:0] lfsr_q;
  logic [2:0] pwr_state;
  logic       lfsr_bit, busy, done, iso_en, save_en, restore_en, sw_en;

  pm_lfsr_domain dut (
    .clk(clk), .rst(rst), .en(en), .seed_ld(seed_ld), .seed(seed),
    .pd_req(pd_req), .pu_req(pu_req), .lfsr_q(lfsr_q), .lfsr_bit(lfsr_bit),
    .pwr_state(pwr_state), .busy(busy), .done(done), .iso_en(iso_en),
    .save_en(save_en), .restore_en(restore_en), .sw_en(sw_en)
  );

  // 8-bit instance, maximal polynomial, short ramps
  logic       rst8 = 1'b0, en8 = 1'b0, seed_ld8 = 1'b0, pd8 = 1'b0, pu8 = 1'b0;
  logic [7:0] seed8 = 8'd0;
  logic [7:0] lfsr8;
  logic [2:0] state8;
  logic       bit8, busy8, done8, iso8, save8, restore8, sw8;

  pm_lfsr_domain #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .SW_DLY(1), .ISO_VAL(8'h00)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .seed_ld(seed_ld8), .seed(seed8),
    .pd_req(pd8), .pu_req(pu8), .lfsr_q(lfsr8), .lfsr_bit(bit8),
    .pwr_state(state8), .busy(busy8), .done(done8), .iso_en(iso8),
    .save_en(save8), .restore_en(restore8), .sw_en(sw8)
  );

  function automatic logic [7:0] step8(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (pwr_state !== 3'd0 || lfsr_q !== 5'b00001 || sw_en !== 1'b1 || iso_en !== 1'b0 ||
        save_en !== 1'b0 || restore_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: state=%0d lfsr=%b sw=%b iso=%b save=%b rest=%b done=%b busy=%b, need 0 00001 1 0 0 0 0 0",
               pwr_state, lfsr_q, sw_en, iso_en, save_en, restore_en, done, busy);
    end
    checks++;
    if (dut.ret_q !== 5'b00000) begin
      failures++;
      $display("FAIL reset_ret: got %b need 00000", dut.ret_q);
    end
  endtask

  task automatic test_lfsr_steps();
    seed_ld = 1'b1; seed = 5'b00001; en = 1'b1;
    tick();
    seed_ld = 1'b0;
    checks++;
    if (lfsr_q !== 5'b00001) begin failures++; $display("FAIL seed_ld_priority: got %b need 00001", lfsr_q); end
    tick();
    checks++;
    if (lfsr_q !== 5'b00010) begin failures++; $display("FAIL step1: got %b need 00010", lfsr_q); end
    tick();
    checks++;
    if (lfsr_q !== 5'b00100) begin failures++; $display("FAIL step2: got %b need 00100", lfsr_q); end
    tick();
    checks++;
    if (lfsr_q !== 5'b01001) begin failures++; $display("FAIL step3: got %b need 01001", lfsr_q); end
    repeat (28) tick();
    checks++;
    if (lfsr_q !== 5'b00001) begin failures++; $display("FAIL period31: got %b need 00001", lfsr_q); end
    repeat (3) tick();
    en = 1'b0;
    checks++;
    if (lfsr_q !== 5'b01001) begin failures++; $display("FAIL rerun_to_01001: got %b need 01001", lfsr_q); end
  endtask

  task automatic test_power_down();
    pd_req = 1'b1;
    tick();
    pd_req = 1'b0;
    checks++;
    if (pwr_state !== 3'd1 || iso_en !== 1'b1 || lfsr_q !== 5'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pd_iso: state=%0d iso=%b lfsr=%b busy=%b need 1 1 00000 1", pwr_state, iso_en, lfsr_q, busy);
    end
    tick();
    checks++;
    if (pwr_state !== 3'd2 || save_en !== 1'b1) begin
      failures++;
      $display("FAIL pd_save: state=%0d save=%b need 2 1", pwr_state, save_en);
    end
    tick();
    checks++;
    if (pwr_state !== 3'd3 || sw_en !== 1'b0 || lfsr_q !== 5'd0 || dut.ret_q !== 5'b01001) begin
      failures++;
      $display("FAIL pd_swoff: state=%0d sw=%b lfsr=%b ret=%b need 3 0 00000 01001", pwr_state, sw_en, lfsr_q, dut.ret_q);
    end
    repeat (3) tick();
    checks++;
    if (pwr_state !== 3'd3 || done !== 1'b0) begin
      failures++;
      $display("FAIL pd_ramp_hold: state=%0d done=%b need 3 0", pwr_state, done);
    end
    tick();
    checks++;
    if (pwr_state !== 3'd4 || done !== 1'b1 || sw_en !== 1'b0 || busy !== 1'b0 || lfsr_q !== 5'd0) begin
      failures++;
      $display("FAIL pd_off: state=%0d done=%b sw=%b busy=%b lfsr=%b need 4 1 0 0 00000", pwr_state, done, sw_en, busy, lfsr_q);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL pd_done_pulse: got %b need 0", done); end
  endtask

  task automatic test_ignored_requests_off();
    pd_req = 1'b1; en = 1'b1; seed_ld = 1'b1; seed = 5'b10101;
    tick();
    pd_req = 1'b0; en = 1'b0; seed_ld = 1'b0;
    checks++;
    if (pwr_state !== 3'd4 || dut.lfsr_st_q !== 5'd0) begin
      failures++;
      $display("FAIL pd_in_off: state=%0d lfsr=%b need 4 00000", pwr_state, dut.lfsr_st_q);
    end
  endtask

  task automatic test_power_up();
    pu_req = 1'b1;
    tick();
    pu_req = 1'b0;
    checks++;
    if (pwr_state !== 3'd5 || sw_en !== 1'b1 || iso_en !== 1'b1) begin
      failures++;
      $display("FAIL pu_swon: state=%0d sw=%b iso=%b need 5 1 1", pwr_state, sw_en, iso_en);
    end
    repeat (4) tick();
    checks++;
    if (pwr_state !== 3'd5) begin failures++; $display("FAIL pu_ramp_hold: state=%0d need 5", pwr_state); end
    tick();
    checks++;
    if (pwr_state !== 3'd6 || restore_en !== 1'b1 || lfsr_q !== 5'd0) begin
      failures++;
      $display("FAIL pu_restore: state=%0d rest=%b lfsr=%b need 6 1 00000", pwr_state, restore_en, lfsr_q);
    end
    tick();
    checks++;
    if (pwr_state !== 3'd7 || iso_en !== 1'b0 || lfsr_q !== 5'b01001 || done !== 1'b0) begin
      failures++;
      $display("FAIL pu_deiso: state=%0d iso=%b lfsr=%b done=%b need 7 0 01001 0", pwr_state, iso_en, lfsr_q, done);
    end
    tick();
    checks++;
    if (pwr_state !== 3'd0 || done !== 1'b1 || lfsr_q !== 5'b01001 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pu_on: state=%0d done=%b lfsr=%b busy=%b need 0 1 01001 0", pwr_state, done, lfsr_q, busy);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (lfsr_q !== 5'b10010 || lfsr_bit !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL pu_next_step: lfsr=%b bit=%b done=%b need 10010 1 0", lfsr_q, lfsr_bit, done);
    end
    pu_req = 1'b1;
    tick();
    pu_req = 1'b0;
    checks++;
    if (pwr_state !== 3'd0 || lfsr_q !== 5'b10010) begin
      failures++;
      $display("FAIL pu_in_on: state=%0d lfsr=%b need 0 10010", pwr_state, lfsr_q);
    end
  endtask

  task automatic test_pd_priority_and_reset();
    pd_req = 1'b1; seed_ld = 1'b1; seed = 5'b10101; en = 1'b1;
    tick();
    pd_req = 1'b0; seed_ld = 1'b0; en = 1'b0;
    tick();
    tick();
    checks++;
    if (pwr_state !== 3'd3 || dut.ret_q !== 5'b10010) begin
      failures++;
      $display("FAIL pd_priority: state=%0d ret=%b need 3 10010", pwr_state, dut.ret_q);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (pwr_state !== 3'd0 || lfsr_q !== 5'b00001 || sw_en !== 1'b1 || iso_en !== 1'b0 || dut.ret_q !== 5'd0) begin
      failures++;
      $display("FAIL rst_in_swoff: state=%0d lfsr=%b sw=%b iso=%b ret=%b need 0 00001 1 0 00000",
               pwr_state, lfsr_q, sw_en, iso_en, dut.ret_q);
    end
    pd_req = 1'b1;
    tick();
    pd_req = 1'b0;
    repeat (6) tick();
    pu_req = 1'b1;
    tick();
    pu_req = 1'b0;
    tick();
    checks++;
    if (pwr_state !== 3'd5) begin failures++; $display("FAIL reach_swon: state=%0d need 5", pwr_state); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (pwr_state !== 3'd0 || lfsr_q !== 5'b00001 || sw_en !== 1'b1 || iso_en !== 1'b0 || dut.ret_q !== 5'd0) begin
      failures++;
      $display("FAIL rst_in_swon: state=%0d lfsr=%b sw=%b iso=%b ret=%b need 0 00001 1 0 00000",
               pwr_state, lfsr_q, sw_en, iso_en, dut.ret_q);
    end
  endtask

  task automatic test_wide();
    logic [7:0] m;
    int         per;
    int         n;
    rst8 = 1'b0;
    tick();
    rst8 = 1'b1;
    per = 0;
    en8 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (per == 0 && lfsr8 == 8'h01) per = i;
    end
    en8 = 1'b0;
    checks++;
    if (per !== 255) begin failures++; $display("FAIL w8_period: got %0d need 255", per); end
    m = 8'h01;
    en8 = 1'b1;
    for (int i = 0; i < 77; i++) begin
      tick();
      m = step8(m);
    end
    en8 = 1'b0;
    checks++;
    if (lfsr8 !== m) begin failures++; $display("FAIL w8_steps: got %h need %h", lfsr8, m); end
    pd8 = 1'b1;
    tick();
    pd8 = 1'b0;
    n = 1;
    while (state8 !== 3'd4 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 4 || done8 !== 1'b1 || lfsr8 !== 8'h00) begin
      failures++;
      $display("FAIL w8_off: cycles=%0d done=%b lfsr=%h need 4 1 00", n, done8, lfsr8);
    end
    pu8 = 1'b1;
    tick();
    pu8 = 1'b0;
    n = 1;
    while (state8 !== 3'd0 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 5 || done8 !== 1'b1 || lfsr8 !== m) begin
      failures++;
      $display("FAIL w8_on: cycles=%0d done=%b lfsr=%h need 5 1 %h", n, done8, lfsr8, m);
    end
    en8 = 1'b1;
    tick();
    en8 = 1'b0;
    m = step8(m);
    checks++;
    if (lfsr8 !== m || bit8 !== m[7]) begin
      failures++;
      $display("FAIL w8_after: lfsr=%h bit=%b need %h %b", lfsr8, bit8, m, m[7]);
    end
  endtask

  initial begin
    tick();
    rst8 = 1'b1;
    test_reset();
    test_lfsr_steps();
    test_power_down();
    test_ignored_requests_off();
    test_power_up();
    test_pd_priority_and_reset();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
